// File: rtl/axi_lite_reg_slice.sv
// ============================================================================
// Module      : axi_lite_reg_slice
// Description : AXI4-Lite register slice; every enabled channel is isolated by
//               a 2-entry skid buffer, disabled channels are plain wires.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module axi_lite_reg_slice #(
  parameter int       C_AXI_ADDR_WIDTH = 32,
  parameter int       C_AXI_DATA_WIDTH = 32,
  parameter logic [4:0] C_CHAN_EN      = 5'b11111
) (
  input  logic                            aclk,
  input  logic                            areset,
  // slave side
  input  logic [C_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  // master side
  output logic [C_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);

  localparam int A_PW = C_AXI_ADDR_WIDTH + 3;
  localparam int W_PW = C_AXI_DATA_WIDTH + C_AXI_DATA_WIDTH / 8;
  localparam int B_PW = 2;
  localparam int R_PW = C_AXI_DATA_WIDTH + 2;

  // ---------------- AW (forward) ----------------
  if (C_CHAN_EN[4]) begin : g_aw_slice
    logic [A_PW-1:0] aw_out;
    axi_lite_reg_slice_skid #(.WIDTH(A_PW)) u_skid (
      .clk       (aclk),
      .rst       (areset),
      .in_valid  (s_axi_awvalid),
      .in_ready  (s_axi_awready),
      .in_data   ({s_axi_awaddr, s_axi_awprot}),
      .out_valid (m_axi_awvalid),
      .out_ready (m_axi_awready),
      .out_data  (aw_out)
    );
    assign {m_axi_awaddr, m_axi_awprot} = aw_out;
  end else begin : g_aw_wire
    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_awvalid = s_axi_awvalid;
    assign s_axi_awready = m_axi_awready;
  end

  // ---------------- W (forward) ----------------
  if (C_CHAN_EN[3]) begin : g_w_slice
    logic [W_PW-1:0] w_out;
    axi_lite_reg_slice_skid #(.WIDTH(W_PW)) u_skid (
      .clk       (aclk),
      .rst       (areset),
      .in_valid  (s_axi_wvalid),
      .in_ready  (s_axi_wready),
      .in_data   ({s_axi_wdata, s_axi_wstrb}),
      .out_valid (m_axi_wvalid),
      .out_ready (m_axi_wready),
      .out_data  (w_out)
    );
    assign {m_axi_wdata, m_axi_wstrb} = w_out;
  end else begin : g_w_wire
    assign m_axi_wdata  = s_axi_wdata;
    assign m_axi_wstrb  = s_axi_wstrb;
    assign m_axi_wvalid = s_axi_wvalid;
    assign s_axi_wready = m_axi_wready;
  end

  // ---------------- B (reverse) ----------------
  if (C_CHAN_EN[2]) begin : g_b_slice
    axi_lite_reg_slice_skid #(.WIDTH(B_PW)) u_skid (
      .clk       (aclk),
      .rst       (areset),
      .in_valid  (m_axi_bvalid),
      .in_ready  (m_axi_bready),
      .in_data   (m_axi_bresp),
      .out_valid (s_axi_bvalid),
      .out_ready (s_axi_bready),
      .out_data  (s_axi_bresp)
    );
  end else begin : g_b_wire
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;
  end

  // ---------------- AR (forward) ----------------
  if (C_CHAN_EN[1]) begin : g_ar_slice
    logic [A_PW-1:0] ar_out;
    axi_lite_reg_slice_skid #(.WIDTH(A_PW)) u_skid (
      .clk       (aclk),
      .rst       (areset),
      .in_valid  (s_axi_arvalid),
      .in_ready  (s_axi_arready),
      .in_data   ({s_axi_araddr, s_axi_arprot}),
      .out_valid (m_axi_arvalid),
      .out_ready (m_axi_arready),
      .out_data  (ar_out)
    );
    assign {m_axi_araddr, m_axi_arprot} = ar_out;
  end else begin : g_ar_wire
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_arvalid = s_axi_arvalid;
    assign s_axi_arready = m_axi_arready;
  end

  // ---------------- R (reverse) ----------------
  if (C_CHAN_EN[0]) begin : g_r_slice
    logic [R_PW-1:0] r_out;
    axi_lite_reg_slice_skid #(.WIDTH(R_PW)) u_skid (
      .clk       (aclk),
      .rst       (areset),
      .in_valid  (m_axi_rvalid),
      .in_ready  (m_axi_rready),
      .in_data   ({m_axi_rdata, m_axi_rresp}),
      .out_valid (s_axi_rvalid),
      .out_ready (s_axi_rready),
      .out_data  (r_out)
    );
    assign {s_axi_rdata, s_axi_rresp} = r_out;
  end else begin : g_r_wire
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;
  end

endmodule

// 2-entry skid buffer: out register faces downstream, skid register absorbs the
// one beat that arrives while the registered in_ready is still high.
module axi_lite_reg_slice_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire;

  // Reset masks the handshake outputs immediately rather than one edge late.
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = out_valid_q & ~rst;
  assign out_data  = out_data_q;
  assign in_fire   = in_valid & in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_data_d   = out_data_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q) begin
      if (in_fire) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end
    end else if (!skid_valid_q) begin
      if (in_fire && out_ready) begin
        out_data_d = in_data;
      end else if (in_fire) begin
        skid_data_d  = in_data;
        skid_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end else if (out_ready) begin
      out_data_d   = skid_data_q;
      skid_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    out_data_q  <= out_data_d;
    skid_data_q <= skid_data_d;
  end

endmodule

`default_nettype wire
